// File: rtl/roi_frame_reader_if.sv
`timescale 1ns/1ps
// Bus bundle for roi_frame_reader: frame RAM read/clear ports plus the downstream pixel stream.
// Stream handshake: a word moves on a cycle where out_valid && out_ready; once out_valid is
// raised it stays high and out_data stays constant until that word is accepted.
interface roi_frame_reader_if #(
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 16
);
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_rd_addr;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_wr_en;
   logic [ADDR_WIDTH-1:0] mem_wr_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wdata, out_data, out_valid,
      input  mem_rdata, out_ready
   );

   modport slave (
      input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wdata, out_data, out_valid,
      output mem_rdata, out_ready
   );
endinterface

// File: rtl/roi_frame_reader.sv
`timescale 1ns/1ps
// Walks a programmed window of the frame RAM in raster order, streams pixels through a
// 2-entry fall-through buffer, and can zero each pixel one cycle after reading it.
module roi_frame_reader #(
   parameter int X_LENGTH     = 320,
   parameter int Y_DEPTH      = 240,
   parameter int X_ADDR_WIDTH = 9,
   parameter int Y_ADDR_WIDTH = 8,
   parameter int ADDR_WIDTH   = 17,
   parameter int DATA_WIDTH   = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rd_req,
   input  logic                    auto_clr,
   input  logic [X_ADDR_WIDTH-1:0] addr_x_start,
   input  logic [X_ADDR_WIDTH-1:0] addr_x_stop,
   input  logic [Y_ADDR_WIDTH-1:0] addr_y_start,
   input  logic [Y_ADDR_WIDTH-1:0] addr_y_stop,
   roi_frame_reader_if.master      bus,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [2:0]              state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_READ  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [X_ADDR_WIDTH:0] X_LEN    = (X_ADDR_WIDTH+1)'(X_LENGTH);
   localparam logic [Y_ADDR_WIDTH:0] Y_LEN    = (Y_ADDR_WIDTH+1)'(Y_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(X_LENGTH);

   state_t                  state, state_nxt;
   logic                    rd_req_q;
   logic                    clr_q;
   logic [X_ADDR_WIDTH-1:0] xs, xe, x;
   logic [Y_ADDR_WIDTH-1:0] ys, ye, y;
   logic [ADDR_WIDTH-1:0]   row_base;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic                    rd_en;
   logic                    rd_pending;
   logic                    wr_en_q;
   logic [ADDR_WIDTH-1:0]   wr_addr_q;
   logic                    start;
   logic                    win_ok;
   logic                    last_pix;

   logic [DATA_WIDTH-1:0]   buf_q [2];
   logic                    buf_rd_ptr, buf_wr_ptr;
   logic [1:0]              buf_cnt, buf_cnt_nxt;
   logic                    fire, push, pop;

   assign start    = rd_req && !rd_req_q;
   assign win_ok   = (xs <= xe) && (ys <= ye) && ({1'b0, xe} < X_LEN) && ({1'b0, ye} < Y_LEN);
   assign rd_addr  = row_base + ADDR_WIDTH'(x);
   assign last_pix = (x == xe) && (y == ye);

   // Credit: stored words plus the read still in flight may never exceed the buffer depth.
   assign rd_en = (state == S_READ) && ((buf_cnt + {1'b0, rd_pending}) < 2'd2);

   // An empty buffer passes the returning RAM word straight through, saving a cycle of latency.
   assign bus.out_valid = (buf_cnt != 2'd0) || rd_pending;
   assign bus.out_data  = (buf_cnt != 2'd0) ? buf_q[buf_rd_ptr] :
                          (rd_pending ? bus.mem_rdata : '0);
   assign fire = bus.out_valid && bus.out_ready;
   assign pop  = fire && (buf_cnt != 2'd0);
   assign push = rd_pending && !(fire && (buf_cnt == 2'd0));

   always_comb begin
      buf_cnt_nxt = buf_cnt;
      case ({push, pop})
         2'b10:   buf_cnt_nxt = buf_cnt + 2'd1;
         2'b01:   buf_cnt_nxt = buf_cnt - 2'd1;
         default: buf_cnt_nxt = buf_cnt;
      endcase
   end

   assign bus.mem_rd_en   = rd_en;
   assign bus.mem_rd_addr = rd_addr;
   assign bus.mem_wr_en   = wr_en_q;
   assign bus.mem_wr_addr = wr_addr_q;
   assign bus.mem_wdata   = '0;
   assign state_dbg       = state;

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nxt = S_CHECK;
         S_CHECK: begin
            if (win_ok) begin
               busy      = 1'b1;
               state_nxt = S_READ;
            end else begin
               err       = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_READ: begin
            busy = 1'b1;
            if (rd_en && last_pix) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            // No reads are issued here, so an empty buffer next cycle means nothing is left.
            if (buf_cnt_nxt == 2'd0) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         rd_req_q   <= 1'b0;
         clr_q      <= 1'b0;
         xs         <= '0;
         xe         <= '0;
         ys         <= '0;
         ye         <= '0;
         x          <= '0;
         y          <= '0;
         row_base   <= '0;
         rd_pending <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
      end else begin
         state      <= state_nxt;
         rd_req_q   <= rd_req;
         rd_pending <= rd_en;
         wr_en_q    <= rd_en && clr_q;
         if (rd_en) wr_addr_q <= rd_addr;
         if ((state == S_IDLE) && start) begin
            xs    <= addr_x_start;
            xe    <= addr_x_stop;
            ys    <= addr_y_start;
            ye    <= addr_y_stop;
            clr_q <= auto_clr;
         end
         if (state == S_CHECK) begin
            x        <= xs;
            y        <= ys;
            row_base <= ADDR_WIDTH'(ys) * ROW_STEP;
         end else if (rd_en) begin
            if (x == xe) begin
               x        <= xs;
               y        <= y + 1'b1;
               row_base <= row_base + ROW_STEP;
            end else begin
               x <= x + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q[0]   <= '0;
         buf_q[1]   <= '0;
         buf_rd_ptr <= 1'b0;
         buf_wr_ptr <= 1'b0;
         buf_cnt    <= 2'd0;
      end else begin
         if (push) begin
            buf_q[buf_wr_ptr] <= bus.mem_rdata;
            buf_wr_ptr        <= ~buf_wr_ptr;
         end
         if (pop) buf_rd_ptr <= ~buf_rd_ptr;
         buf_cnt <= buf_cnt_nxt;
      end
   end

endmodule
